seg7_scan_mux: RTL

- Consumes the slow toggling scan clock from the debug clock divider and time-multiplexes up to 8 hex digits onto a common-anode 7-segment display.
- Runs entirely in the system clock domain. The slow scan signal is used only as an enable source (rising-edge detect), never as a clock.
- Latches the display value once per full scan frame, so digits never tear mid-frame.
- Optional leading-zero blanking.

---
 rtl/seg7_scan_mux.sv | 138 +++++++++++++
 1 files changed

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed hex driver for a common-anode 7-segment display.
// The slow scan signal is only edge-detected as an enable; everything runs on clk.
module seg7_scan_mux #(
   parameter int NUM_DIGITS = 8,
   parameter int IDX_W      = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    scan_in,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic                    lzb,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic                    frame
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

   logic                    scan_q, scan_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic                    valid_q, valid_d;
   logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d;
   logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
   logic [NUM_DIGITS-1:0]   shadow_en_q, shadow_en_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic [6:0]              seg_q, seg_d;
   logic                    dp_q, dp_d;
   logic                    frame_q, frame_d;

   logic                    step;
   logic                    load;
   logic [3:0]              nibble;
   logic [NUM_DIGITS-1:0]   nibble_zero;
   logic [NUM_DIGITS-1:0]   upper_mask;
   logic                    zero_blank;
   logic                    blank;

   // Active-high segment pattern, bit order gfedcba.
   function automatic logic [6:0] seg_pattern(input logic [3:0] n);
      logic [6:0] p;
      case (n)
         4'h0: p = 7'h3F;
         4'h1: p = 7'h06;
         4'h2: p = 7'h5B;
         4'h3: p = 7'h4F;
         4'h4: p = 7'h66;
         4'h5: p = 7'h6D;
         4'h6: p = 7'h7D;
         4'h7: p = 7'h07;
         4'h8: p = 7'h7F;
         4'h9: p = 7'h6F;
         4'hA: p = 7'h77;
         4'hB: p = 7'h7C;
         4'hC: p = 7'h39;
         4'hD: p = 7'h5E;
         4'hE: p = 7'h79;
         default: p = 7'h71;
      endcase
      return p;
   endfunction

   // Scan sequencing: a frame reloads the shadow on the first step and on each wrap.
   always_comb begin
      step         = scan_in & ~scan_q;
      load         = step & (~valid_q | (idx_q == LAST_IDX));
      scan_d       = scan_in;
      idx_d        = idx_q;
      valid_d      = valid_q;
      shadow_val_d = shadow_val_q;
      shadow_dp_d  = shadow_dp_q;
      shadow_en_d  = shadow_en_q;
      frame_d      = load;
      if (step) begin
         valid_d = 1'b1;
         idx_d   = load ? '0 : idx_q + 1'b1;
      end
      if (load) begin
         shadow_val_d = value;
         shadow_dp_d  = dp_in;
         shadow_en_d  = digit_en;
      end
   end

   // A digit is zero-blanked when every nibble from idx upward is zero;
   // bits below idx are forced to 1 in the comparison via the mask.
   always_comb begin
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
         nibble_zero[k] = (shadow_val_q[4*k +: 4] == 4'h0);
      end
      upper_mask = {NUM_DIGITS{1'b1}} << idx_q;
      nibble     = shadow_val_q[4*idx_q +: 4];
      zero_blank = lzb && (idx_q != '0) && ((nibble_zero | ~upper_mask) == {NUM_DIGITS{1'b1}});
      blank      = ~valid_q | ~shadow_en_q[idx_q] | zero_blank;
      an_d       = '1;
      seg_d      = 7'h7F;
      dp_d       = 1'b1;
      if (!blank) begin
         an_d[idx_q] = 1'b0;
         seg_d       = ~seg_pattern(nibble);
         dp_d        = ~shadow_dp_q[idx_q];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         scan_q       <= 1'b0;
         idx_q        <= '0;
         valid_q      <= 1'b0;
         shadow_val_q <= '0;
         shadow_dp_q  <= '0;
         shadow_en_q  <= '0;
         an_q         <= '1;
         seg_q        <= 7'h7F;
         dp_q         <= 1'b1;
         frame_q      <= 1'b0;
      end else begin
         scan_q       <= scan_d;
         idx_q        <= idx_d;
         valid_q      <= valid_d;
         shadow_val_q <= shadow_val_d;
         shadow_dp_q  <= shadow_dp_d;
         shadow_en_q  <= shadow_en_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         frame_q      <= frame_d;
      end
   end

   assign an    = an_q;
   assign seg   = seg_q;
   assign dp    = dp_q;
   assign frame = frame_q;

endmodule
